pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Ports SHALL be, clock and reset first:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- ResultSrcE, ResultSrcM  in  2  result select; 2'b01 means load.
- RegWriteM, RegWriteW  in  1  register write enables.
- memwriteM  in  1  store in Memory.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- mem_ready  in  1  data memory access completes this cycle.
- ForwardAE, ForwardBE  out  2  operand forward select: 00 register file, 01 Writeback, 10 Memory.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register to a bubble.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  16  count of memory-wait cycles.
REQ-003 The block SHALL have one parameter, TIMEOUT, default 255: the number of wait cycles before an error is flagged.

Function
REQ-004 Forwarding SHALL be combinational. ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E.
REQ-005 A memory access SHALL be defined as mem_acc = memwriteM | (ResultSrcM==2'b01).
REQ-006 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-007 RUN transitions:
- mem_acc & !mem_ready -> MEM_WAIT, wait_cnt<=1.
- otherwise stay in RUN.
REQ-008 MEM_WAIT transitions:
- mem_ready -> RUN, wait_cnt<=0.
- else if wait_cnt==TIMEOUT -> ERROR.
- else wait_cnt<=wait_cnt+1.
REQ-009 ERROR SHALL be terminal until reset, and mem_err SHALL be 1 in ERROR.
REQ-010 mem_stall = (mem_acc & !mem_ready & state!=ERROR) | (state==ERROR), computed combinationally so the stall applies in the same cycle.
REQ-011 When mem_stall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Load-use and branch actions SHALL be suppressed; they re-evaluate on the first unstalled cycle.
REQ-012 When mem_stall=0, lduse = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-013 When mem_stall=0: StallF=StallD=lduse; FlushE=lduse|PCSrcE; FlushD=PCSrcE; StallE=StallM=FlushW=0.
REQ-014 When lduse and PCSrcE are both 1, FlushD and FlushE SHALL be 1 and StallF and StallD SHALL be 1.
REQ-015 stall_cycles SHALL increment by 1 on each clock edge where mem_stall=1, saturating at 16'hFFFF.
REQ-016 wait_cnt SHALL be 8 bits wide, and TIMEOUT SHALL be at most 255.

Reset
REQ-017 On reset assertion, asynchronously: state=RUN, wait_cnt=0, stall_cycles=0, mem_err=0.
REQ-018 Asserting reset while in MEM_WAIT or ERROR SHALL return the block to RUN, with outputs governed only by REQ-004 and REQ-013 from then on.
REQ-019 No internal state SHALL change on a clock edge while reset=1.

Verification
REQ-020 Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Same stimulus with RdM=0 -> ForwardAE=01.
REQ-021 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 and FlushD=0 for one cycle. Same stimulus with RdE=0 -> all stall and flush outputs 0.
REQ-022 Branch: PCSrcE=1, no load -> FlushD=FlushE=1 and StallF=0, for one cycle.
REQ-023 Memory wait: memwriteM=1 with mem_ready low for 3 cycles, then high -> StallF..StallM=1 and FlushW=1 for 3 cycles, then all 0; stall_cycles=3; state back in RUN.
REQ-024 Timeout with TIMEOUT=4: mem_acc=1 and mem_ready=0 held -> ERROR entered on the 5th edge, mem_err=1, stalls held even after mem_ready rises; reset -> mem_err=0, stall_cycles=0.
REQ-025 Overlap: mem_stall concurrent with PCSrcE=1 -> FlushD=FlushE=0 while stalled; on the cycle mem_ready=1 -> FlushD=FlushE=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bundle: register IDs, result selects, write enables, memory status in;
// forward selects, per-stage stall/flush, sticky memory error and wait-cycle count out.
// Latency: n/a (wires only). Backpressure: n/a; the controller's stalls are the backpressure.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [4:0]  RdM, RdW;
  logic [1:0]  ResultSrcE, ResultSrcM;
  logic        RegWriteM, RegWriteW;
  logic        memwriteM;
  logic        PCSrcE;
  logic        mem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        mem_err;
  logic [15:0] stall_cycles;

  // Pipeline datapath side: drives register IDs and status, observes hazard decisions.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE, ResultSrcM, RegWriteM, RegWriteW,
    output memwriteM, PCSrcE, mem_ready,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  mem_err, stall_cycles
  );

  // Hazard controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE, ResultSrcM, RegWriteM, RegWriteW,
    input  memwriteM, PCSrcE, mem_ready,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output mem_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch flush, memory-wait stall with timeout.
// Latency: forward/stall/flush are combinational (same cycle); mem_err/stall_cycles update on the clock edge.
// Backpressure: a pending memory access (mem_ready low) freezes F..M and bubbles W until ready or ERROR.
// Ports: clock, reset (async active-high), hz (pipeline_hazard_ctrl_if.slave bundle).
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  pipeline_hazard_ctrl_if.slave       hz
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
  localparam logic [1:0] RES_LOAD  = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic mem_acc;
  logic mem_stall;
  logic lduse;

  // Memory-stage forwarding takes priority: it holds the younger result.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E)) begin
      hz.ForwardAE = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E)) begin
      hz.ForwardAE = 2'b01;
    end
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E)) begin
      hz.ForwardBE = 2'b10;
    end else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E)) begin
      hz.ForwardBE = 2'b01;
    end
  end

  assign mem_acc = hz.memwriteM | (hz.ResultSrcM == RES_LOAD);

  // Stall in the very cycle mem_ready is low, not one cycle later; ERROR freezes the pipe for good.
  assign mem_stall = (mem_acc & ~hz.mem_ready & (state_q != ERROR)) | (state_q == ERROR);

  assign lduse = (hz.ResultSrcE == RES_LOAD) & (hz.RdE != 5'd0) &
                 ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

  // A memory stall masks load-use and branch actions; they re-evaluate once the pipe moves again.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.StallF = lduse;
      hz.StallD = lduse;
      hz.FlushE = lduse | hz.PCSrcE;
      hz.FlushD = hz.PCSrcE;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_acc && !hz.mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (mem_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Reset branch holds every register at its reset value for as long as reset is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.mem_err      = (state_q == ERROR);
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hif.slave)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl;
  assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};

  localparam logic [6:0] CTL_NONE   = 7'b0000_000;
  localparam logic [6:0] CTL_MEM    = 7'b1111_001;
  localparam logic [6:0] CTL_LDUSE  = 7'b1100_010;
  localparam logic [6:0] CTL_BRANCH = 7'b0000_110;
  localparam logic [6:0] CTL_BOTH   = 7'b1100_110;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic clear_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    hif.Rs1E = 5'd0; hif.Rs2E = 5'd0; hif.RdE = 5'd0;
    hif.RdM = 5'd0;  hif.RdW = 5'd0;
    hif.ResultSrcE = 2'b00; hif.ResultSrcM = 2'b00;
    hif.RegWriteM = 1'b0;   hif.RegWriteW = 1'b0;
    hif.memwriteM = 1'b0;   hif.PCSrcE = 1'b0;
    hif.mem_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NONE); end
    n_checks++;
    if ({hif.ForwardAE, hif.ForwardBE} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_fwd: got %b%b want 0000", hif.ForwardAE, hif.ForwardBE);
    end
    n_checks++;
    if (hif.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b want 0", hif.mem_err); end
    n_checks++;
    if (hif.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", hif.stall_cycles);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    // {RegWriteM, RegWriteW, RdM, RdW, Rs1E, Rs2E, expA, expB}
    logic [1:0] wm [6] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10};
    logic [4:0] rdm[6] = '{5'd5, 5'd0, 5'd5, 5'd3, 5'd9, 5'd4};
    logic [4:0] rdw[6] = '{5'd5, 5'd5, 5'd5, 5'd4, 5'd0, 5'd4};
    logic [4:0] r1 [6] = '{5'd5, 5'd5, 5'd5, 5'd3, 5'd0, 5'd1};
    logic [4:0] r2 [6] = '{5'd1, 5'd5, 5'd2, 5'd4, 5'd0, 5'd4};
    logic [1:0] ea [6] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [1:0] eb [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      clear_inputs();
      {hif.RegWriteM, hif.RegWriteW} = wm[i];
      hif.RdM = rdm[i]; hif.RdW = rdw[i]; hif.Rs1E = r1[i]; hif.Rs2E = r2[i];
      #2;
      n_checks++;
      if (hif.ForwardAE !== ea[i]) begin
        n_fail++; $display("FAIL fwd_A[%0d]: got %b want %b", i, hif.ForwardAE, ea[i]);
      end
      n_checks++;
      if (hif.ForwardBE !== eb[i]) begin
        n_fail++; $display("FAIL fwd_B[%0d]: got %b want %b", i, hif.ForwardBE, eb[i]);
      end
    end
  endtask

  task automatic test_load_use();
    @(negedge clock);
    clear_inputs();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7; hif.Rs1D = 5'd3;
    #2;
    n_checks++;
    if (ctl !== CTL_LDUSE) begin n_fail++; $display("FAIL lduse_rs2: got %b want %b", ctl, CTL_LDUSE); end
    @(negedge clock);
    hif.ResultSrcE = 2'b00; hif.RdE = 5'd0;  // bubble has moved into Execute
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lduse_release: got %b want %b", ctl, CTL_NONE); end
    @(negedge clock);
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lduse_x0: got %b want %b", ctl, CTL_NONE); end
    @(negedge clock);
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd12; hif.Rs1D = 5'd12; hif.Rs2D = 5'd1;
    #2;
    n_checks++;
    if (ctl !== CTL_LDUSE) begin n_fail++; $display("FAIL lduse_rs1: got %b want %b", ctl, CTL_LDUSE); end
    @(negedge clock);
    hif.ResultSrcE = 2'b10;  // not a load
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lduse_notload: got %b want %b", ctl, CTL_NONE); end
  endtask

  task automatic test_branch();
    @(negedge clock);
    clear_inputs();
    hif.PCSrcE = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_BRANCH) begin n_fail++; $display("FAIL branch: got %b want %b", ctl, CTL_BRANCH); end
    @(negedge clock);
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd9; hif.Rs1D = 5'd9;
    #2;
    n_checks++;
    if (ctl !== CTL_BOTH) begin n_fail++; $display("FAIL branch_lduse: got %b want %b", ctl, CTL_BOTH); end
    @(negedge clock);
    clear_inputs();
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL branch_release: got %b want %b", ctl, CTL_NONE); end
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    clear_inputs();
    hif.memwriteM = 1'b1; hif.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (ctl !== CTL_MEM) begin n_fail++; $display("FAIL memwait_stall[%0d]: got %b want %b", i, ctl, CTL_MEM); end
      @(negedge clock);
    end
    hif.mem_ready = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL memwait_ready: got %b want %b", ctl, CTL_NONE); end
    @(posedge clock);
    #1;
    n_checks++;
    if (hif.stall_cycles !== 16'd3) begin
      n_fail++; $display("FAIL memwait_count: got %0d want 3", hif.stall_cycles);
    end
    n_checks++;
    if (dut.state_q !== 2'b00) begin n_fail++; $display("FAIL memwait_state: got %b want 00", dut.state_q); end
    n_checks++;
    if (hif.mem_err !== 1'b0) begin n_fail++; $display("FAIL memwait_err: got %b want 0", hif.mem_err); end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_timeout();
    pulse_reset();
    clear_inputs();
    hif.ResultSrcM = 2'b01; hif.mem_ready = 1'b0;  // load access this time
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (hif.mem_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", hif.mem_err); end
    @(posedge clock);
    #1;
    n_checks++;
    if (hif.mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", hif.mem_err); end
    n_checks++;
    if (hif.stall_cycles !== 16'd5) begin
      n_fail++; $display("FAIL timeout_count: got %0d want 5", hif.stall_cycles);
    end
    @(negedge clock);
    hif.mem_ready = 1'b1; hif.PCSrcE = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_MEM) begin n_fail++; $display("FAIL timeout_hold: got %b want %b", ctl, CTL_MEM); end
    @(posedge clock);
    #1;
    n_checks++;
    if ({hif.mem_err, hif.stall_cycles} !== {1'b1, 16'd6}) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b cnt=%0d want err=1 cnt=6", hif.mem_err, hif.stall_cycles);
    end
    #1;
    reset = 1'b1;  // asynchronous: takes effect between edges
    #1;
    n_checks++;
    if ({hif.mem_err, hif.stall_cycles} !== {1'b0, 16'd0}) begin
      n_fail++; $display("FAIL timeout_reset: got err=%b cnt=%0d want err=0 cnt=0", hif.mem_err, hif.stall_cycles);
    end
    hif.PCSrcE = 1'b0; hif.mem_ready = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if ({dut.state_q, hif.stall_cycles} !== {2'b00, 16'd0}) begin
      n_fail++; $display("FAIL reset_hold: got state=%b cnt=%0d want state=00 cnt=0", dut.state_q, hif.stall_cycles);
    end
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    hif.PCSrcE = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_BRANCH) begin n_fail++; $display("FAIL post_reset_branch: got %b want %b", ctl, CTL_BRANCH); end
  endtask

  task automatic test_overlap();
    @(negedge clock);
    clear_inputs();
    hif.memwriteM = 1'b1; hif.mem_ready = 1'b0; hif.PCSrcE = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_MEM) begin n_fail++; $display("FAIL overlap_stalled: got %b want %b", ctl, CTL_MEM); end
    @(negedge clock);
    #2;
    n_checks++;
    if (ctl !== CTL_MEM) begin n_fail++; $display("FAIL overlap_stalled2: got %b want %b", ctl, CTL_MEM); end
    @(negedge clock);
    hif.mem_ready = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CTL_BRANCH) begin n_fail++; $display("FAIL overlap_release: got %b want %b", ctl, CTL_BRANCH); end
    @(posedge clock);
    #1;
    n_checks++;
    if (hif.stall_cycles !== 16'd2) begin
      n_fail++; $display("FAIL overlap_count: got %0d want 2", hif.stall_cycles);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
